// File: rtl/approx_eval_pkg.sv
// Shared types, width helpers and default parameters for the approximate-circuit
// exhaustive evaluators.
package approx_eval_pkg;

   localparam int DEF_N_IN  = 4;
   localparam int DEF_N_OUT = 4;
   localparam int DEF_ET    = 5;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DRAIN,
      DONE
   } state_t;

   // One extra bit lets the count reach 2^nIn when every vector is wrong.
   function automatic int errCountWidth(input int nIn);
      return nIn + 1;
   endfunction

   function automatic int sumErrWidth(input int nIn, input int nOut);
      return nIn + nOut;
   endfunction

endpackage

// File: rtl/exact_abs_err.sv
// Combinational exact product of the two stimulus operands, truncated to the
// netlist output width, and its absolute distance from the approximate output.
module exact_abs_err #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 4
) (
   input  logic [N_IN-1:0]  i_stim,
   input  logic [N_OUT-1:0] i_approx,
   output logic [N_OUT-1:0] o_absErr
);

   localparam int A_W = N_IN / 2;
   localparam int PW  = 2 * A_W;

   logic [A_W-1:0]   w_a;
   logic [A_W-1:0]   w_b;
   logic [PW-1:0]    w_prod;
   logic [N_OUT-1:0] w_exact;

   assign w_a     = i_stim[A_W-1:0];
   assign w_b     = i_stim[N_IN-1:A_W];
   assign w_prod  = {{A_W{1'b0}}, w_a} * {{A_W{1'b0}}, w_b};
   // The cast truncates when N_OUT < PW and zero-extends otherwise.
   assign w_exact = N_OUT'(w_prod);

   always_comb begin
      o_absErr = '0;
      if (w_exact >= i_approx) begin
         o_absErr = w_exact - i_approx;
      end else begin
         o_absErr = i_approx - w_exact;
      end
   end

endmodule

// File: rtl/approx_err_monitor.sv
// Exhaustive sweep of an approximate multiplier netlist: drives every input
// vector, measures the error of each result and reports max/count/sum and pass.
module approx_err_monitor
   import approx_eval_pkg::*;
#(
   parameter int N_IN  = DEF_N_IN,
   parameter int N_OUT = DEF_N_OUT,
   parameter int ET    = DEF_ET
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   output logic [N_IN-1:0]                       stim_o,
   output logic                                  stim_valid_o,
   input  logic [N_OUT-1:0]                      approx_i,
   output logic                                  busy,
   output logic                                  done,
   output logic [N_OUT-1:0]                      max_err,
   output logic [errCountWidth(N_IN)-1:0]        err_count,
   output logic [sumErrWidth(N_IN, N_OUT)-1:0]   sum_err,
   output logic                                  pass
);

   localparam int          CW      = errCountWidth(N_IN);
   localparam int          SW      = sumErrWidth(N_IN, N_OUT);
   localparam logic [31:0] ET_U    = 32'(ET);
   localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);

   state_t            r_state;
   state_t            w_nextState;
   logic [N_IN-1:0]   r_vec;
   logic              r_stimValid;
   logic [N_OUT-1:0]  r_pipeErr;
   logic              r_pipeValid;
   logic [N_OUT-1:0]  r_maxErr;
   logic [CW-1:0]     r_errCount;
   logic [SW-1:0]     r_sumErr;
   logic              r_pass;
   logic [N_OUT-1:0]  w_absErr;
   logic [N_OUT-1:0]  w_maxNext;
   logic              w_startAccept;
   logic              w_lastVec;
   logic              w_passNext;

   assign w_startAccept = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_lastVec     = (r_vec == '1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = SWEEP;
         SWEEP:   if (w_lastVec) w_nextState = DRAIN;
         DRAIN:   w_nextState = DONE;
         DONE:    if (start) w_nextState = SWEEP;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         SWEEP:   busy = 1'b1;
         DRAIN:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // The last vector stays on stim_o through DRAIN and DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vec       <= '0;
         r_stimValid <= 1'b0;
      end else if (w_startAccept) begin
         r_vec       <= '0;
         r_stimValid <= 1'b1;
      end else if (r_state == SWEEP) begin
         if (w_lastVec) begin
            r_stimValid <= 1'b0;
         end else begin
            r_vec <= r_vec + VEC_ONE;
         end
      end
   end

   assign stim_o       = r_vec;
   assign stim_valid_o = r_stimValid;

   exact_abs_err #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT)
   ) u_exactAbsErr (
      .i_stim   (r_vec),
      .i_approx (approx_i),
      .o_absErr (w_absErr)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pipeErr   <= '0;
         r_pipeValid <= 1'b0;
      end else begin
         r_pipeErr   <= w_absErr;
         r_pipeValid <= r_stimValid;
      end
   end

   // pass must include the final pipe entry, which lands on the same edge.
   assign w_maxNext  = (r_pipeValid && (r_pipeErr > r_maxErr)) ? r_pipeErr : r_maxErr;
   assign w_passNext = (32'(w_maxNext) <= ET_U);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_maxErr   <= '0;
         r_errCount <= '0;
         r_sumErr   <= '0;
         r_pass     <= 1'b0;
      end else if (w_startAccept) begin
         r_maxErr   <= '0;
         r_errCount <= '0;
         r_sumErr   <= '0;
         r_pass     <= 1'b0;
      end else begin
         if (r_pipeValid) begin
            r_maxErr   <= w_maxNext;
            r_errCount <= r_errCount + CW'(r_pipeErr != '0);
            r_sumErr   <= r_sumErr + SW'(r_pipeErr);
         end
         if (r_state == DRAIN) begin
            r_pass <= w_passNext;
         end
      end
   end

   assign max_err   = r_maxErr;
   assign err_count = r_errCount;
   assign sum_err   = r_sumErr;
   assign pass      = r_pass;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor: several behavioural netlist models,
// mid-sweep reset, ignored starts and restart from DONE.
module tb_approx_err_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] stim_o;
   logic       stim_valid_o;
   logic [3:0] approx_i;
   logic       busy;
   logic       done;
   logic [3:0] max_err;
   logic [4:0] err_count;
   logic [7:0] sum_err;
   logic       pass;

   int errors = 0;
   int checks = 0;
   int mode   = 0;

   always #5 clk = ~clk;

   approx_err_monitor #(
      .N_IN  (4),
      .N_OUT (4),
      .ET    (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stim_o       (stim_o),
      .stim_valid_o (stim_valid_o),
      .approx_i     (approx_i),
      .busy         (busy),
      .done         (done),
      .max_err      (max_err),
      .err_count    (err_count),
      .sum_err      (sum_err),
      .pass         (pass)
   );

   // Netlist models: 0 exact, 1 stuck-at-0, 2 stuck-at-15, 3 exact except 3*3 -> 4.
   logic [3:0] modelProd;
   always_comb begin
      modelProd = {2'b00, stim_o[1:0]} * {2'b00, stim_o[3:2]};
      approx_i  = modelProd;
      case (mode)
         1:       approx_i = 4'd0;
         2:       approx_i = 4'd15;
         3:       if (stim_o == 4'hF) approx_i = 4'd4;
         default: ;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkResults(input int expMax, input int expCount, input int expSum, input int expPass);
      checkOutput("maxErr", 32'(max_err), 32'(expMax));
      checkOutput("errCount", 32'(err_count), 32'(expCount));
      checkOutput("sumErr", 32'(sum_err), 32'(expSum));
      checkOutput("pass", 32'(pass), 32'(expPass));
      checkOutput("doneBusy", 32'(busy), 32'd0);
   endtask

   // Pulses start, then follows the sweep cycle by cycle; start is re-asserted
   // in cycles ignoredAt1/ignoredAt2 (0 disables) to probe that it is ignored.
   task automatic applyStimulus(input int ignoredAt1, input int ignoredAt2);
      int cycle;
      int vecErr;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycle  = 1;
      vecErr = 0;
      checkOutput("startBusy", 32'(busy), 32'd1);
      checkOutput("startDoneClr", 32'(done), 32'd0);
      checkOutput("startPassClr", 32'(pass), 32'd0);
      checkOutput("startStatsClr", {20'd0, max_err, err_count, sum_err}, 32'd0);
      while (done !== 1'b1 && cycle < 40) begin
         if (cycle <= 16) begin
            if (stim_valid_o !== 1'b1 || stim_o !== 4'(cycle - 1)) vecErr++;
         end else if (stim_valid_o !== 1'b0 || stim_o !== 4'hF) begin
            vecErr++;
         end
         start = (cycle == ignoredAt1) || (cycle == ignoredAt2);
         @(negedge clk);
         cycle++;
      end
      start = 1'b0;
      checkOutput("doneLatency", 32'(cycle), 32'd18);
      checkOutput("vecSeq", 32'(vecErr), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 0;
      repeat (2) @(negedge clk);
      checkOutput("rstStim", {27'd0, stim_valid_o, stim_o}, 32'd0);
      checkOutput("rstFlags", {29'd0, busy, done, pass}, 32'd0);
      checkOutput("rstStats", {20'd0, max_err, err_count, sum_err}, 32'd0);
      rst_n = 1'b1;

      mode = 0;
      applyStimulus(0, 0);
      checkResults(0, 0, 0, 1);

      mode = 1;
      applyStimulus(0, 0);
      checkResults(9, 9, 36, 0);

      // |exact - 15| summed: 16*15 - 36 = 204.
      mode = 2;
      applyStimulus(0, 0);
      checkResults(15, 16, 204, 0);

      mode = 3;
      applyStimulus(0, 0);
      checkResults(5, 1, 5, 1);

      mode = 3;
      applyStimulus(5, 17);
      checkResults(5, 1, 5, 1);
      @(negedge clk);
      checkOutput("doneHeld", 32'(done), 32'd1);
      checkOutput("sumHeld", 32'(sum_err), 32'd5);

      mode = 1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      checkOutput("preRstSumNonzero", 32'(sum_err != 8'd0), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("midRstFlags", {29'd0, busy, done, pass}, 32'd0);
      checkOutput("midRstValid", 32'(stim_valid_o), 32'd0);
      checkOutput("midRstStats", {20'd0, max_err, err_count, sum_err}, 32'd0);

      applyStimulus(0, 0);
      checkResults(9, 9, 36, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
